// File: rtl/tia_f3_pkg.sv
// Shared definitions for the TIA F3 set/reset flip-flop cell.
// The set and clear pairs use active-low AND terms, built from a NOR.
package tia_f3_pkg;

   localparam logic Q_RESET = 1'b0;

   // A pair requests its action only when both inputs are low.
   function automatic logic pair_active(input logic a, input logic b);
      return ~(a | b);
   endfunction

endpackage

// File: rtl/tia_f3.sv
// TIA "F3" clocked set/reset flip-flop with complementary outputs.
// Priority on each rising edge: reset, then clear, then set, then hold.
module tia_f3
   import tia_f3_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic s1,
   input  logic s2,
   input  logic r1,
   input  logic r2,
   output logic q,
   output logic q_bar
);

   logic q_q = Q_RESET;
   logic q_d;
   logic set_req;
   logic clr_req;

   assign set_req = pair_active(s1, s2);
   assign clr_req = pair_active(r1, r2);

   // Clear dominates a simultaneous set.
   always_comb begin
      q_d = q_q;
      if (clr_req) begin
         q_d = 1'b0;
      end else if (set_req) begin
         q_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         q_q <= Q_RESET;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign q_bar = ~q_q;

endmodule

// File: tb/tb_tia_f3.sv
// Self-checking bench for tia_f3: a table of directed vectors followed by
// random vectors, each with its expected q pushed to a scoreboard queue.
module tb_tia_f3;

   typedef struct {
      logic rst;
      logic s1;
      logic s2;
      logic r1;
      logic r2;
      logic exp_q;
   } vec_t;

   logic clock;
   logic reset;
   logic s1;
   logic s2;
   logic r1;
   logic r2;
   logic q;
   logic q_bar;

   int   n_vec;
   int   n_err;
   logic exp_q_queue[$];
   logic model_q;
   vec_t tbl[17];

   tia_f3 dut (
      .clock (clock),
      .reset (reset),
      .s1    (s1),
      .s2    (s2),
      .r1    (r1),
      .r2    (r2),
      .q     (q),
      .q_bar (q_bar)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic exp_q);
      n_vec++;
      if (q !== exp_q || q_bar !== ~exp_q) begin
         n_err++;
         $display("FAIL %s: q=%b q_bar=%b, required q=%b q_bar=%b",
                  name, q, q_bar, exp_q, ~exp_q);
      end
   endtask

   // Called at a negedge (or time 0): drive, score, compare after the posedge.
   task automatic apply(input string name, input vec_t v);
      logic exp;
      reset = v.rst;
      s1    = v.s1;
      s2    = v.s2;
      r1    = v.r1;
      r2    = v.r2;
      exp_q_queue.push_back(v.exp_q);
      @(posedge clock);
      #1;
      if (exp_q_queue.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: scoreboard empty, required one entry", name);
      end else begin
         exp = exp_q_queue.pop_front();
         check(name, exp);
      end
      @(negedge clock);
      if (!v.rst) begin
         check({name, "_negedge"}, 1'b0);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;

      //        rst   s1    s2    r1    r2    q
      tbl = '{
         '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // reset state
         '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1},  // set
         '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},  // hold set
         '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},  // clear
         '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},  // hold clear
         '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},  // set again
         '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},  // reset beats set
         '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
         '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},  // half set pair: hold 0
         '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},  // set
         '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1},  // half clear pair: hold 1
         '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1},  // both pairs half: hold 1
         '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // clear dominates
         '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},  // set
         '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}   // clear dominates from 1
      };

      for (int unsigned i = 0; i < 17; i++) begin
         apply($sformatf("tbl%0d", i), tbl[i]);
      end

      // Random vectors scored by an independent behavioural model.
      model_q = 1'b0;
      for (int unsigned i = 0; i < 60; i++) begin
         vec_t v;
         v.rst = ($urandom_range(0, 7) != 0);
         v.s1  = 1'($urandom_range(0, 1));
         v.s2  = 1'($urandom_range(0, 1));
         v.r1  = 1'($urandom_range(0, 1));
         v.r2  = 1'($urandom_range(0, 1));
         if (!v.rst)                 model_q = 1'b0;
         else if (!v.r1 && !v.r2)    model_q = 1'b0;
         else if (!v.s1 && !v.s2)    model_q = 1'b1;
         v.exp_q = model_q;
         apply($sformatf("rnd%0d", i), v);
      end

      if (exp_q_queue.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d entries left, required 0", exp_q_queue.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
